d_sram_axi_bridge: RTL and testbench
====================================

Name: d_sram_axi_bridge

Overview:
- Converts the data cache's sram-like memory port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) into single-beat AXI read and write channels.
- Sits directly downstream of the write-back data cache and upstream of the AXI crossbar.
- Allows exactly one outstanding transaction, so no IDs, bursts or reordering are needed.

Parameters:
- ADDR_WIDTH, 32, width of sram-side and AXI addresses.

Ports:
- clk in 1 clock
- rst in 1 reset: synchronous, active-high
- req in 1 sram request
- wr in 1 1=write, 0=read
- size in 2 0=byte, 1=half, 2=word
- addr in ADDR_WIDTH byte address
- wdata in 32 lane-aligned write data
- rdata out 32 read data, valid with data_ok
- addr_ok out 1 request accepted
- data_ok out 1 transaction complete
- araddr out ADDR_WIDTH read address
- arsize out 3 read size
- arvalid out 1
- arready in 1
- r_rdata in 32
- rvalid in 1
- rready out 1
- awaddr out ADDR_WIDTH write address
- awsize out 3 write size
- awvalid out 1
- awready in 1
- w_wdata out 32
- wstrb out 4 byte enables
- wvalid out 1
- wready in 1
- bvalid in 1
- bready out 1

Behaviour:
- FSM states: IDLE, AR, R, AWW, B. Reset puts the FSM in IDLE.
- Reset clears arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok and both done flags. rst forces addr_ok and data_ok to 0 combinationally. Reset mid-transaction abandons the transaction; the bench must not assert AXI responses after reset.
- addr_ok = req & (state==IDLE), combinational.
  - On accept, latch wr, size, addr and wdata.
  - Go to AR if wr=0, else go to AWW.
- AR: arvalid=1, araddr=latched addr, arsize={1'b0,size}. On arready, go to R. arvalid never depends on arready.
- R: rready=1. When rvalid=1:
  - data_ok=1 for one cycle.
  - rdata=r_rdata, combinational pass-through.
  - Return to IDLE.
- AWW: awvalid and wvalid both assert on entry and drop independently.
  - awvalid clears on awready (aw_done=1); wvalid clears on wready (w_done=1).
  - Move to B when both handshakes are complete, including when they complete in the same cycle.
  - Order of the two handshakes is free; a W handshake before AW is legal.
- B: bready=1. On bvalid, data_ok=1 for one cycle, clear the done flags, go to IDLE.
- Responses: rresp and bresp are not monitored; no error path.
- wstrb rules:
  - size 0: 4'b0001 shifted left by addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2 or 3: 4'b1111 (size 3 treated as word).
- Pass-through: w_wdata=latched wdata unshifted; araddr/awaddr are not realigned.
- Acceptance timing: addr_ok is low in every non-IDLE state. The cycle data_ok pulses cannot also accept; the next request is accepted at the earliest one cycle later.
- Minimum latency, with accept at T0 and ready/valid high immediately:
  - Read: arvalid at T1, data_ok at T2.
  - Write: awvalid/wvalid at T1, B at T2, data_ok at T2.
- Changes to req, addr or wdata after accept have no effect on the transaction in flight.

Test Plan:
- Read word addr 0x1FC0_0010, arready=1, rvalid one cycle later with r_rdata=0xDEADBEEF → araddr=0x1FC0_0010, arsize=3'b010, data_ok=1 with rdata=0xDEADBEEF exactly 2 cycles after addr_ok.
- Store byte addr 0x0000_0103, wdata=0xAA000000 → wstrb=4'b1000, awsize=3'b000, w_wdata=0xAA000000, one data_ok after bvalid.
- Store half addr 0x0000_0202, wready asserted 3 cycles before awready → wvalid drops after its handshake, awvalid stays high until awready, B phase is entered only after both.
- Back-to-back read then write with req held high → addr_ok low during the read, second addr_ok the cycle after the read's data_ok, write fields latched from the second request.
- arready held low 5 cycles while addr changes → arvalid and araddr stay stable, no addr_ok, data_ok only after the eventual rvalid.
- rst asserted while in R → next cycle rready=0, arvalid=0, state IDLE, addr_ok=1 if req is high.

Source files
------------

// File: rtl/d_sram_axi_bridge_if.sv
// AXI-side bundle of the data-cache bridge: single-beat AR/R/AW/W/B.
// master: bridge drives addresses/valids; slave: crossbar side.
interface d_sram_axi_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           r_rdata;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           w_wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arsize, arvalid,
    input  arready,
    input  r_rdata, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output w_wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  araddr, arsize, arvalid,
    output arready,
    output r_rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  w_wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/d_sram_axi_bridge.sv
// Data-cache sram-like port to single-beat AXI, one transaction in flight.
// Ports: clk/rst, sram req/wr/size/addr/wdata -> addr_ok/data_ok/rdata, axi (master).
module d_sram_axi_bridge #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  d_sram_axi_bridge_if.master   axi
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  aw_ok, w_ok;

  // A channel counts as done if it already handshook or does so now,
  // so simultaneous AW/W completion still advances in one cycle.
  assign aw_ok = aw_done_q | axi.awready;
  assign w_ok  = w_done_q  | axi.wready;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    addr_ok   = req & (state_q == S_IDLE);
    data_ok   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_ok) begin
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = wr ? S_AWW : S_AR;
        end
      end
      S_AR: begin
        if (axi.arready) state_d = S_R;
      end
      S_R: begin
        if (axi.rvalid) begin
          data_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_AWW: begin
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) state_d = S_B;
      end
      S_B: begin
        if (axi.bvalid) begin
          data_ok   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      state_d   = S_IDLE;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    aw_done_q <= aw_done_d;
    w_done_q  <= w_done_d;
    size_q    <= size_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
  end

  always_comb begin
    case (size_q)
      2'd0:    axi.wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    axi.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: axi.wstrb = 4'b1111;
    endcase
  end

  assign axi.araddr  = addr_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arvalid = (state_q == S_AR);
  assign axi.rready  = (state_q == S_R);
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awvalid = (state_q == S_AWW) & ~aw_done_q;
  assign axi.w_wdata = wdata_q;
  assign axi.wvalid  = (state_q == S_AWW) & ~w_done_q;
  assign axi.bready  = (state_q == S_B);
  assign rdata       = axi.r_rdata;

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Directed bench for d_sram_axi_bridge: vector table plus corner sequences.
// Inputs change at posedge+1, outputs are sampled on the falling edge.
module tb_d_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;

  int n_tests = 0;
  int n_fail  = 0;

  d_sram_axi_bridge_if #(.ADDR_WIDTH(32)) axi ();

  d_sram_axi_bridge #(.ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .axi     (axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_axi();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.r_rdata = 32'h0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    // T0: accept
    req = 1'b1; wr = v.wr; size = v.size;
    addr = v.addr; wdata = v.wdata;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    smp();
    chk($sformatf("v%0d addr_ok", i), addr_ok, 1);
    // T1: address phase, scramble sram inputs
    tick();
    req = 1'b0; addr = ~v.addr; wdata = ~v.wdata; size = ~v.size;
    smp();
    chk($sformatf("v%0d addr_ok_t1", i), addr_ok, 0);
    if (!v.wr) begin
      chk($sformatf("v%0d arvalid", i), axi.arvalid, 1);
      chk($sformatf("v%0d araddr", i), axi.araddr, v.addr);
      chk($sformatf("v%0d arsize", i), axi.arsize, v.exp_size);
      chk($sformatf("v%0d awvalid", i), axi.awvalid, 0);
    end else begin
      chk($sformatf("v%0d awvalid", i), axi.awvalid, 1);
      chk($sformatf("v%0d wvalid", i), axi.wvalid, 1);
      chk($sformatf("v%0d awaddr", i), axi.awaddr, v.addr);
      chk($sformatf("v%0d awsize", i), axi.awsize, v.exp_size);
      chk($sformatf("v%0d wstrb", i), axi.wstrb, v.exp_strb);
      chk($sformatf("v%0d w_wdata", i), axi.w_wdata, v.wdata);
      chk($sformatf("v%0d arvalid", i), axi.arvalid, 0);
    end
    chk($sformatf("v%0d data_ok_t1", i), data_ok, 0);
    // T2: response
    tick();
    if (!v.wr) begin
      axi.rvalid = 1'b1; axi.r_rdata = v.rd;
    end else begin
      axi.bvalid = 1'b1;
    end
    smp();
    chk($sformatf("v%0d data_ok", i), data_ok, 1);
    if (!v.wr) begin
      chk($sformatf("v%0d rready", i), axi.rready, 1);
      chk($sformatf("v%0d rdata", i), rdata, v.rd);
    end else begin
      chk($sformatf("v%0d bready", i), axi.bready, 1);
      chk($sformatf("v%0d awvalid_b", i), axi.awvalid, 0);
    end
    // T3: back to idle
    tick();
    idle_axi();
    smp();
    chk($sformatf("v%0d data_ok_t3", i), data_ok, 0);
    chk($sformatf("v%0d rready_t3", i), axi.rready, 0);
    chk($sformatf("v%0d bready_t3", i), axi.bready, 0);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0010, 32'h0, 32'hDEAD_BEEF, 3'b010, 4'b1111};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_0103, 32'hAA00_0000, 32'h0, 3'b000, 4'b1000};
    vecs[2] = '{1'b1, 2'd0, 32'h0000_0100, 32'h0000_0055, 32'h0, 3'b000, 4'b0001};
    vecs[3] = '{1'b1, 2'd0, 32'h0000_0401, 32'h0000_6600, 32'h0, 3'b000, 4'b0010};
    vecs[4] = '{1'b1, 2'd1, 32'h0000_0202, 32'h1234_0000, 32'h0, 3'b001, 4'b1100};
    vecs[5] = '{1'b1, 2'd1, 32'h0000_0200, 32'h0000_5678, 32'h0, 3'b001, 4'b0011};
    vecs[6] = '{1'b1, 2'd3, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 3'b011, 4'b1111};
    vecs[7] = '{1'b0, 2'd0, 32'h0000_0041, 32'h0, 32'h0000_7700, 3'b000, 4'b0001};

    rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2;
    addr = 32'h0; wdata = 32'h0;
    idle_axi();
    tick(); tick();
    smp();
    chk("rst addr_ok", addr_ok, 0);
    chk("rst data_ok", data_ok, 0);
    chk("rst arvalid", axi.arvalid, 0);
    chk("rst awvalid", axi.awvalid, 0);
    chk("rst wvalid", axi.wvalid, 0);
    chk("rst rready", axi.rready, 0);
    chk("rst bready", axi.bready, 0);
    tick();
    rst = 1'b0; req = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Half store: W handshakes 3 cycles before AW.
    req = 1'b1; wr = 1'b1; size = 2'd1;
    addr = 32'h0000_0202; wdata = 32'hBEEF_0000;
    smp();
    chk("hw addr_ok", addr_ok, 1);
    tick();
    req = 1'b0; axi.wready = 1'b1;
    smp();
    chk("hw awvalid t1", axi.awvalid, 1);
    chk("hw wvalid t1", axi.wvalid, 1);
    chk("hw wstrb", axi.wstrb, 4'b1100);
    for (int k = 2; k <= 3; k++) begin
      tick();
      axi.wready = 1'b0;
      smp();
      chk($sformatf("hw wvalid t%0d", k), axi.wvalid, 0);
      chk($sformatf("hw awvalid t%0d", k), axi.awvalid, 1);
      chk($sformatf("hw bready t%0d", k), axi.bready, 0);
    end
    tick();
    axi.awready = 1'b1;
    smp();
    chk("hw awvalid t4", axi.awvalid, 1);
    chk("hw bready t4", axi.bready, 0);
    tick();
    axi.awready = 1'b0; axi.bvalid = 1'b1;
    smp();
    chk("hw bready t5", axi.bready, 1);
    chk("hw awvalid t5", axi.awvalid, 0);
    chk("hw data_ok t5", data_ok, 1);
    tick();
    idle_axi();
    smp();
    chk("hw data_ok t6", data_ok, 0);
    tick();

    // Back-to-back read then write, req held high.
    req = 1'b1; wr = 1'b0; size = 2'd2;
    addr = 32'h0000_1000; wdata = 32'h0;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    smp();
    chk("bb addr_ok0", addr_ok, 1);
    tick();
    wr = 1'b1; addr = 32'h0000_2004; wdata = 32'h0BAD_F00D;
    smp();
    chk("bb addr_ok1", addr_ok, 0);
    chk("bb araddr", axi.araddr, 32'h0000_1000);
    tick();
    axi.rvalid = 1'b1; axi.r_rdata = 32'h1111_2222;
    smp();
    chk("bb data_ok2", data_ok, 1);
    chk("bb addr_ok2", addr_ok, 0);
    chk("bb rdata", rdata, 32'h1111_2222);
    tick();
    axi.rvalid = 1'b0;
    smp();
    chk("bb addr_ok3", addr_ok, 1);
    chk("bb data_ok3", data_ok, 0);
    tick();
    req = 1'b0;
    smp();
    chk("bb awvalid", axi.awvalid, 1);
    chk("bb awaddr", axi.awaddr, 32'h0000_2004);
    chk("bb w_wdata", axi.w_wdata, 32'h0BAD_F00D);
    chk("bb wstrb", axi.wstrb, 4'b1111);
    tick();
    axi.bvalid = 1'b1;
    smp();
    chk("bb data_ok5", data_ok, 1);
    tick();
    idle_axi();
    tick();

    // arready stalled 5 cycles while sram inputs move.
    req = 1'b1; wr = 1'b0; size = 2'd2;
    addr = 32'h0000_0300;
    smp();
    chk("st addr_ok", addr_ok, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      addr = 32'h0000_0300 + 32'(k * 16);
      smp();
      chk($sformatf("st arvalid t%0d", k), axi.arvalid, 1);
      chk($sformatf("st araddr t%0d", k), axi.araddr, 32'h0000_0300);
      chk($sformatf("st addr_ok t%0d", k), addr_ok, 0);
    end
    tick();
    axi.arready = 1'b1;
    smp();
    chk("st arvalid t6", axi.arvalid, 1);
    tick();
    axi.arready = 1'b0;
    smp();
    chk("st rready t7", axi.rready, 1);
    chk("st data_ok t7", data_ok, 0);
    chk("st addr_ok t7", addr_ok, 0);
    tick();
    req = 1'b0; axi.rvalid = 1'b1; axi.r_rdata = 32'h0000_0C0C;
    smp();
    chk("st data_ok t8", data_ok, 1);
    chk("st rdata", rdata, 32'h0000_0C0C);
    tick();
    idle_axi();
    tick();

    // Reset while waiting in R.
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0400;
    axi.arready = 1'b1;
    smp();
    chk("rr addr_ok", addr_ok, 1);
    tick();
    req = 1'b0;
    tick();
    axi.arready = 1'b0;
    smp();
    chk("rr rready", axi.rready, 1);
    tick();
    rst = 1'b1; req = 1'b1; addr = 32'h0000_0500;
    smp();
    chk("rr addr_ok in rst", addr_ok, 0);
    chk("rr data_ok in rst", data_ok, 0);
    tick();
    rst = 1'b0; axi.arready = 1'b1;
    smp();
    chk("rr rready after", axi.rready, 0);
    chk("rr arvalid after", axi.arvalid, 0);
    chk("rr addr_ok after", addr_ok, 1);
    tick();
    req = 1'b0;
    smp();
    chk("rr arvalid new", axi.arvalid, 1);
    chk("rr araddr new", axi.araddr, 32'h0000_0500);
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.r_rdata = 32'h5555_AAAA;
    smp();
    chk("rr data_ok new", data_ok, 1);
    tick();
    idle_axi();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
